// File: rtl/blink_scheduler.sv
// Arbitrates error/success blink requests and runs the start/done handshake
// with an external blinker, followed by a fixed idle gap.
module blink_scheduler #(
    parameter logic [31:0] GAP_CYCLES  = 32'd1200000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic hwclk,
    input  logic reset_n,
    input  logic req_error,
    input  logic req_success,
    input  logic done_blinking,
    output logic start_blinking,
    output logic blinkType,
    output logic ack_error,
    output logic ack_success,
    output logic busy,
    output logic fault
);

    localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_GAP
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic          r_errLow;
    logic          r_succLow;
    logic          r_pendErr;
    logic          r_pendSucc;
    logic          r_blinkType;
    logic          r_fault;
    logic          r_ackErr;
    logic          r_ackSucc;
    logic [TW-1:0] r_timeout;
    logic [31:0]   r_gap;

    logic w_errEdge;
    logic w_succEdge;
    logic w_timeoutHit;
    logic w_gapDone;
    logic w_start;
    logic w_loadType;
    logic w_typeNext;
    logic w_clrPend;
    logic w_setFault;
    logic w_ackErr;
    logic w_ackSucc;

    // r_*Low records "input seen low", so a request already high at reset release never counts.
    assign w_errEdge    = req_error & r_errLow;
    assign w_succEdge   = req_success & r_succLow;
    assign w_timeoutHit = (32'(r_timeout) + 32'd1) >= 32'(ACK_TIMEOUT);
    assign w_gapDone    = (GAP_CYCLES == 32'd0) || (r_gap >= (GAP_CYCLES - 32'd1));

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_loadType  = 1'b0;
        w_typeNext  = r_blinkType;
        w_clrPend   = 1'b0;
        w_setFault  = 1'b0;
        w_ackErr    = 1'b0;
        w_ackSucc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pendErr || r_pendSucc) begin
                    w_loadType  = 1'b1;
                    w_typeNext  = ~r_pendErr;
                    w_stateNext = S_SETUP;
                end
            end
            S_SETUP: begin
                w_stateNext = S_START;
            end
            S_START: begin
                w_start     = 1'b1;
                w_stateNext = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                w_start = 1'b1;
                if (!done_blinking) begin
                    w_stateNext = S_WAIT_HIGH;
                end else if (w_timeoutHit) begin
                    w_setFault  = 1'b1;
                    w_clrPend   = 1'b1;
                    w_stateNext = S_GAP;
                end
            end
            S_WAIT_HIGH: begin
                w_start = 1'b1;
                if (done_blinking) begin
                    w_clrPend   = 1'b1;
                    w_ackErr    = ~r_blinkType;
                    w_ackSucc   = r_blinkType;
                    w_stateNext = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gapDone) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // A fresh request edge wins over the clear of the same pending bit.
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            r_errLow    <= 1'b0;
            r_succLow   <= 1'b0;
            r_pendErr   <= 1'b0;
            r_pendSucc  <= 1'b0;
            r_blinkType <= 1'b0;
            r_fault     <= 1'b0;
            r_ackErr    <= 1'b0;
            r_ackSucc   <= 1'b0;
            r_timeout   <= '0;
            r_gap       <= 32'd0;
        end else begin
            r_errLow   <= ~req_error;
            r_succLow  <= ~req_success;
            r_pendErr  <= w_errEdge | (r_pendErr & ~(w_clrPend & ~r_blinkType));
            r_pendSucc <= w_succEdge | (r_pendSucc & ~(w_clrPend & r_blinkType));
            if (w_loadType) begin
                r_blinkType <= w_typeNext;
            end
            if (w_setFault) begin
                r_fault <= 1'b1;
            end
            r_ackErr  <= w_ackErr;
            r_ackSucc <= w_ackSucc;
            if (r_state == S_START) begin
                r_timeout <= '0;
            end else if (r_state == S_WAIT_LOW && r_timeout != TMAX) begin
                r_timeout <= r_timeout + TW'(1);
            end
            if (r_state != S_GAP) begin
                r_gap <= 32'd0;
            end else if (r_gap != 32'hFFFF_FFFF) begin
                r_gap <= r_gap + 32'd1;
            end
        end
    end

    assign start_blinking = w_start;
    assign blinkType      = r_blinkType;
    assign ack_error      = r_ackErr;
    assign ack_success    = r_ackSucc;
    assign busy           = (r_state != S_IDLE);
    assign fault          = r_fault;

endmodule

// File: tb/tb_blink_scheduler.sv
// Self-checking bench for blink_scheduler: directed scenarios plus randomized
// request/injection trials compared against a transaction-level pending model.
module tb_blink_scheduler;

   localparam logic [31:0] GAP = 32'd4;
   localparam int          TMO = 16;

   logic hwclk = 1'b0;
   logic reset_n = 1'b0;
   logic req_error = 1'b0;
   logic req_success = 1'b0;
   logic done_blinking = 1'b1;
   logic start_blinking;
   logic blinkType;
   logic ack_error;
   logic ack_success;
   logic busy;
   logic fault;

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int obsSeq[$];
   int obsAck[$];
   int expSeq[$];
   int startRiseCycle = 0;
   int startFallCycle = 0;
   int ackCycle = 0;
   int busyFallCycle = 0;
   int lastEdgeCycle = 0;
   int dropDelay = 2;
   int highDelay = 20;
   bit blinkerStuck = 1'b0;

   int  trialMask;
   int  injMask;
   int  act;
   bit  pe;
   bit  ps;
   bit  first;

   blink_scheduler #(
      .GAP_CYCLES (GAP),
      .ACK_TIMEOUT(TMO)
   ) dut (
      .hwclk         (hwclk),
      .reset_n       (reset_n),
      .req_error     (req_error),
      .req_success   (req_success),
      .done_blinking (done_blinking),
      .start_blinking(start_blinking),
      .blinkType     (blinkType),
      .ack_error     (ack_error),
      .ack_success   (ack_success),
      .busy          (busy),
      .fault         (fault)
   );

   // Free-running clock and a cycle counter that advances on every rising edge
   initial forever #5 hwclk = ~hwclk;

   initial forever begin
      @(posedge hwclk);
      cycle++;
   end

   // Every comparison point funnels through here so counting stays in one place
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse the selected requests high for 'width' sampling edges, then low again
   task automatic applyStimulus(input bit err, input bit succ, input int width);
      @(posedge hwclk);
      #1;
      if (err) req_error = 1'b1;
      if (succ) req_success = 1'b1;
      lastEdgeCycle = cycle;
      repeat (width) @(posedge hwclk);
      #1;
      if (err) req_error = 1'b0;
      if (succ) req_success = 1'b0;
   endtask

   // Idle means busy has stayed low for several cycles, so nothing is pending
   task automatic waitIdle(input string tag);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 2000) begin
         @(negedge hwclk);
         n++;
         quiet = busy ? 0 : quiet + 1;
      end
      checkOutput({tag, "_idleReached"}, 32'(n < 2000), 32'd1);
   endtask

   task automatic waitDoneLow(input string tag);
      int n = 0;
      while (done_blinking && n < 100) begin
         @(negedge hwclk);
         n++;
      end
      checkOutput({tag, "_doneFell"}, 32'(n < 100), 32'd1);
   endtask

   task automatic clearObs();
      obsSeq.delete();
      obsAck.delete();
   endtask

   function automatic int qAt(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // Behavioural blinker: drops done some cycles after start rises, raises it later
   initial begin
      bit blkPrev = 1'b0;
      forever begin
         @(negedge hwclk);
         if (start_blinking && !blkPrev && !blinkerStuck) begin
            blkPrev = 1'b1;
            repeat (dropDelay) @(posedge hwclk);
            #1 done_blinking = 1'b0;
            repeat (highDelay) @(posedge hwclk);
            #1 done_blinking = 1'b1;
         end else begin
            blkPrev = start_blinking;
         end
      end
   end

   // Monitor: logs sequence starts and acks, checks type stability and ack width
   initial begin
      logic pStart = 1'b0;
      logic pType = 1'b0;
      logic pAckE = 1'b0;
      logic pAckS = 1'b0;
      logic pBusy = 1'b0;
      forever begin
         @(negedge hwclk);
         if (reset_n) begin
            if (start_blinking && !pStart) begin
               obsSeq.push_back(int'(blinkType));
               startRiseCycle = cycle;
               checkOutput("typeStableBeforeStart", 32'(blinkType), 32'(pType));
            end
            if (!start_blinking && pStart) startFallCycle = cycle;
            if (ack_error) begin
               if (!pAckE) begin
                  obsAck.push_back(0);
                  ackCycle = cycle;
               end
               checkOutput("ackErrorOneCycle", 32'(pAckE), 32'd0);
            end
            if (ack_success) begin
               if (!pAckS) begin
                  obsAck.push_back(1);
                  ackCycle = cycle;
               end
               checkOutput("ackSuccessOneCycle", 32'(pAckS), 32'd0);
            end
            if (!busy && pBusy) busyFallCycle = cycle;
         end
         pStart = start_blinking;
         pType  = blinkType;
         pAckE  = ack_error;
         pAckS  = ack_success;
         pBusy  = busy;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge hwclk);
      #1;
      checkOutput("rst_start", 32'(start_blinking), 32'd0);
      checkOutput("rst_type", 32'(blinkType), 32'd0);
      checkOutput("rst_ackErr", 32'(ack_error), 32'd0);
      checkOutput("rst_ackSucc", 32'(ack_success), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_fault", 32'(fault), 32'd0);
      @(negedge hwclk);
      reset_n = 1'b1;
      repeat (3) @(posedge hwclk);

      // Single error request: latency, type, ack, gap length
      $display("[TB] single error request");
      clearObs();
      applyStimulus(1'b1, 1'b0, 1);
      waitIdle("single");
      checkOutput("single_startLatency", 32'(startRiseCycle - (lastEdgeCycle + 1)), 32'd2);
      checkOutput("single_seqCount", 32'(obsSeq.size()), 32'd1);
      checkOutput("single_seqType", 32'(qAt(obsSeq, 0)), 32'd0);
      checkOutput("single_ackCount", 32'(obsAck.size()), 32'd1);
      checkOutput("single_ackType", 32'(qAt(obsAck, 0)), 32'd0);
      checkOutput("single_gapCycles", 32'(busyFallCycle - ackCycle), GAP);

      // Simultaneous requests: error first, success second
      $display("[TB] simultaneous requests");
      clearObs();
      applyStimulus(1'b1, 1'b1, 2);
      waitIdle("simul");
      checkOutput("simul_seqCount", 32'(obsSeq.size()), 32'd2);
      checkOutput("simul_seq0", 32'(qAt(obsSeq, 0)), 32'd0);
      checkOutput("simul_seq1", 32'(qAt(obsSeq, 1)), 32'd1);
      checkOutput("simul_ack0", 32'(qAt(obsAck, 0)), 32'd0);
      checkOutput("simul_ack1", 32'(qAt(obsAck, 1)), 32'd1);

      // Held request registers once
      $display("[TB] held success request");
      clearObs();
      applyStimulus(1'b0, 1'b1, 200);
      waitIdle("held");
      checkOutput("held_seqCount", 32'(obsSeq.size()), 32'd1);
      checkOutput("held_ackCount", 32'(obsAck.size()), 32'd1);
      checkOutput("held_ackType", 32'(qAt(obsAck, 0)), 32'd1);

      // Two error pulses during an active success sequence give one error sequence
      $display("[TB] requests during busy");
      clearObs();
      applyStimulus(1'b0, 1'b1, 1);
      waitDoneLow("busyReq");
      applyStimulus(1'b1, 1'b0, 1);
      repeat (2) @(posedge hwclk);
      applyStimulus(1'b1, 1'b0, 1);
      waitIdle("busyReq");
      checkOutput("busyReq_seqCount", 32'(obsSeq.size()), 32'd2);
      checkOutput("busyReq_seq0", 32'(qAt(obsSeq, 0)), 32'd1);
      checkOutput("busyReq_seq1", 32'(qAt(obsSeq, 1)), 32'd0);
      checkOutput("busyReq_ackCount", 32'(obsAck.size()), 32'd2);

      // Randomized trials against the pending-set model
      $display("[TB] randomized trials");
      for (int t = 0; t < 8; t++) begin
         trialMask = int'($urandom_range(1, 3));
         injMask   = int'($urandom_range(0, 3));
         dropDelay = int'($urandom_range(1, 4));
         highDelay = int'($urandom_range(12, 20));
         clearObs();
         applyStimulus(trialMask[0], trialMask[1], int'($urandom_range(1, 3)));
         if (injMask != 0) begin
            waitDoneLow("rand");
            applyStimulus(injMask[0], injMask[1], 1);
         end
         waitIdle("rand");
         expSeq.delete();
         pe = trialMask[0];
         ps = trialMask[1];
         first = 1'b1;
         while (pe || ps) begin
            act = pe ? 0 : 1;
            expSeq.push_back(act);
            if (first) begin
               if (injMask[0] && act != 0) pe = 1'b1;
               if (injMask[1] && act != 1) ps = 1'b1;
            end
            if (act == 0) pe = 1'b0;
            else ps = 1'b0;
            first = 1'b0;
         end
         checkOutput("rand_seqCount", 32'(obsSeq.size()), 32'(expSeq.size()));
         checkOutput("rand_ackCount", 32'(obsAck.size()), 32'(expSeq.size()));
         for (int i = 0; i < expSeq.size(); i++) begin
            checkOutput("rand_seqType", 32'(qAt(obsSeq, i)), 32'(expSeq[i]));
            checkOutput("rand_ackType", 32'(qAt(obsAck, i)), 32'(expSeq[i]));
         end
      end

      // Handshake timeout sets a sticky fault and produces no ack
      $display("[TB] handshake timeout");
      dropDelay = 2;
      highDelay = 20;
      blinkerStuck = 1'b1;
      clearObs();
      applyStimulus(1'b0, 1'b1, 1);
      waitIdle("tmo");
      checkOutput("tmo_fault", 32'(fault), 32'd1);
      checkOutput("tmo_startHighCycles", 32'(startFallCycle - startRiseCycle), 32'(1 + TMO));
      checkOutput("tmo_ackCount", 32'(obsAck.size()), 32'd0);
      checkOutput("tmo_seqCount", 32'(obsSeq.size()), 32'd1);
      blinkerStuck = 1'b0;
      clearObs();
      applyStimulus(1'b1, 1'b0, 1);
      waitIdle("afterTmo");
      checkOutput("afterTmo_ackType", 32'(qAt(obsAck, 0)), 32'd0);
      checkOutput("afterTmo_faultSticky", 32'(fault), 32'd1);

      // Reset during WAIT_HIGH with the request held across it
      $display("[TB] mid-sequence reset");
      clearObs();
      highDelay = 30;
      @(posedge hwclk);
      #1 req_error = 1'b1;
      waitDoneLow("midRst");
      repeat (3) @(posedge hwclk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midRst_start", 32'(start_blinking), 32'd0);
      checkOutput("midRst_type", 32'(blinkType), 32'd0);
      checkOutput("midRst_busy", 32'(busy), 32'd0);
      checkOutput("midRst_ackErr", 32'(ack_error), 32'd0);
      checkOutput("midRst_ackSucc", 32'(ack_success), 32'd0);
      checkOutput("midRst_fault", 32'(fault), 32'd0);
      repeat (40) @(posedge hwclk);
      clearObs();
      #1 reset_n = 1'b1;
      repeat (30) @(negedge hwclk);
      checkOutput("midRst_noNewSeq", 32'(obsSeq.size()), 32'd0);
      checkOutput("midRst_noAck", 32'(obsAck.size()), 32'd0);
      checkOutput("midRst_idle", 32'(busy), 32'd0);
      @(posedge hwclk);
      #1 req_error = 1'b0;
      repeat (2) @(posedge hwclk);
      applyStimulus(1'b1, 1'b0, 1);
      waitIdle("rearm");
      checkOutput("rearm_seqType", 32'(qAt(obsSeq, 0)), 32'd0);
      checkOutput("rearm_ackCount", 32'(obsAck.size()), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/blink_scheduler.md
BLINK_SCHEDULER -- requirements
Module: blink_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 32'd1200000, SHALL set the number of idle cycles between consecutive blink sequences (0.1 s at 12 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum cycles the block waits for done_blinking to fall after start.
REQ-003 hwclk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_error  input  1  SHALL request an error blink sequence (blinkType 0); level sampled each cycle.
REQ-006 req_success  input  1  SHALL request a programming-success blink sequence (blinkType 1); level sampled each cycle.
REQ-007 done_blinking  input  1  SHALL be the blinker's status: low while blinking, high when finished.
REQ-008 start_blinking  output  1  SHALL be the start level to the blinker; its rising edge starts a sequence.
REQ-009 blinkType  output  1  SHALL select the sequence type; it is stable from one cycle before start_blinking rises until the sequence ends.
REQ-010 ack_error, ack_success  output  1 each  SHALL be one-cycle pulses when the matching sequence completes.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 fault  output  1  SHALL be a sticky flag set on handshake timeout.

Function
REQ-013 Each request SHALL set a pending bit on a 0->1 edge only; a held-high request SHALL register once.
REQ-014 A pending bit SHALL stay set until its sequence completes; repeat edges while pending SHALL be absorbed.
REQ-015 States SHALL be IDLE, SETUP, START, WAIT_LOW, WAIT_HIGH, GAP.
REQ-016 IDLE: when any bit is pending, the block SHALL pick error before success, drive blinkType, and go to SETUP.
REQ-017 SETUP: the block SHALL hold blinkType for one cycle with start_blinking=0, then go to START.
REQ-018 START: the block SHALL drive start_blinking=1, clear the timeout counter, and go to WAIT_LOW.
REQ-019 WAIT_LOW: start_blinking SHALL stay 1; on done_blinking=0 go to WAIT_HIGH; after ACK_TIMEOUT cycles with no fall, set fault, clear that pending bit, drop start_blinking, and go to GAP.
REQ-020 WAIT_HIGH: start_blinking SHALL stay 1; on done_blinking=1 drop start_blinking, pulse the matching ack for one cycle, clear that pending bit, and go to GAP. No timeout applies.
REQ-021 GAP: the block SHALL count GAP_CYCLES cycles with start_blinking=0, then go to IDLE. With GAP_CYCLES=0 it SHALL spend exactly one cycle in GAP.
REQ-022 The gap counter SHALL be 32 bits and the timeout counter $clog2(ACK_TIMEOUT+1) bits; neither SHALL wrap, saturating at its terminal value.
REQ-023 Arbitration SHALL happen only in IDLE; a request arriving mid-sequence SHALL never pre-empt the active one.
REQ-024 If req_error and req_success rise in the same cycle, both SHALL become pending and error SHALL be served first.
REQ-025 A request edge in the same cycle its pending bit clears SHALL leave the bit set (set wins).
REQ-026 fault SHALL clear only on reset.

Reset
REQ-027 When reset_n is low, state SHALL be IDLE and these outputs SHALL be 0: start_blinking, blinkType, ack_error, ack_success, busy, fault. Pending bits, counters and edge-detect registers SHALL also be 0.
REQ-028 Reset asserted mid-sequence SHALL drop start_blinking immediately (asynchronously), with no ack pulse.
REQ-029 After reset_n deasserts, a request input already high SHALL NOT register until it goes low and then high again.

Verification (GAP_CYCLES=4, ACK_TIMEOUT=16, behavioural blinker model)
REQ-030 Single error request: pulse req_error; blinker drops done 2 cycles after start and raises it 20 cycles later -> blinkType=0, start rises 2 cycles after the req edge, exactly one ack_error pulse, busy low 4 gap cycles later.
REQ-031 Simultaneous requests: req_error and req_success rise together -> error sequence first, then 4-cycle gap, then success sequence with blinkType=1; ack_error precedes ack_success.
REQ-032 Held request: req_success held high for 200 cycles -> exactly one success sequence and one ack_success.
REQ-033 Timeout: done_blinking stuck high -> fault=1 after 16 cycles in WAIT_LOW, no ack, return to IDLE, fault still 1 afterwards.
REQ-034 Mid-sequence reset: assert reset_n=0 during WAIT_HIGH -> start_blinking=0 in the same cycle, all outputs 0, no ack; with req held high across reset, no new sequence starts.
REQ-035 Request during busy: pulse req_error twice during an active success sequence -> exactly one error sequence follows after the gap.
